// File: rtl/keypad_entry_display.sv
// Matrix keypad scanner with debounce, numeric entry buffer and multiplexed 7-segment driver.
// Optional auto-repeat while a key is held is built when KEY_REPEAT_EN is defined.
module keypad_entry_display #(
  parameter int N_ROW       = 4,
  parameter int N_COL       = 4,
  parameter int N_DIGIT     = 8,
  parameter int MODE        = 0,
  parameter int SCAN_DIV    = 1000,
  parameter int DEB_CYCLES  = 200000,
`ifdef KEY_REPEAT_EN
  parameter int REPEAT_DLY  = 25000000,
  parameter int REPEAT_RATE = 5000000,
`endif
  parameter int REFRESH_DIV = 50000
) (
  input  logic               CLK,
  input  logic               RST,
  output logic [N_ROW-1:0]   KEY_ROW,
  input  logic [N_COL-1:0]   KEY_COL,
  output logic [3:0]         KEY_VALUE,
  output logic               VALUE_EN,
  output logic [3:0]         ENTRY_CNT,
  output logic [N_DIGIT-1:0] SEL,
  output logic [7:0]         SEG
);
  localparam int ROW_W = (N_ROW > 1) ? $clog2(N_ROW) : 1;
  localparam int COL_W = (N_COL > 1) ? $clog2(N_COL) : 1;
  localparam int DIG_W = (N_DIGIT > 1) ? $clog2(N_DIGIT) : 1;
  localparam logic [31:0] SCAN_LAST = 32'(SCAN_DIV - 1);
  localparam logic [31:0] DEB_LAST  = 32'(DEB_CYCLES - 1);
  localparam logic [31:0] REF_LAST  = 32'(REFRESH_DIV - 1);
  localparam logic [3:0]  DIGIT_MAX = 4'(N_DIGIT);
`ifdef KEY_REPEAT_EN
  localparam logic [31:0] RPT_DLY_LAST  = 32'(REPEAT_DLY - 1);
  localparam logic [31:0] RPT_RATE_LAST = 32'(REPEAT_RATE - 1);
`endif

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [N_ROW-1:0] row_drive(input logic [ROW_W-1:0] r);
    return ~(N_ROW'(1) << r);
  endfunction

  state_t           state;
  logic [31:0]      cnt;
  logic [ROW_W-1:0] row_idx;
  logic [ROW_W-1:0] row_next;
  logic [COL_W-1:0] col_lat;
  logic [COL_W-1:0] low_col;
  logic [3:0]       key_code;
  logic             all_high;
  logic [N_COL-1:0] col_p0;
  logic [N_COL-1:0] col_p1;
`ifdef KEY_REPEAT_EN
  logic [31:0]      rpt_cnt;
  logic             rpt_first;
`endif

  // Stage p0/p1: two-flop synchroniser on the column inputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      col_p0 <= '1;
      col_p1 <= '1;
    end else begin
      col_p0 <= KEY_COL;
      col_p1 <= col_p0;
    end
  end

  always_comb begin
    low_col = '0;
    for (int c = N_COL - 1; c >= 0; c--)
      if (!col_p1[c]) low_col = COL_W'(c);
  end

  assign all_high = &col_p1;
  assign row_next = (row_idx == ROW_W'(N_ROW - 1)) ? '0 : row_idx + 1'b1;
  assign key_code = 4'(int'(row_idx) * N_COL + int'(col_lat));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= SCAN;
      cnt       <= '0;
      row_idx   <= '0;
      col_lat   <= '0;
      KEY_ROW   <= row_drive('0);
      KEY_VALUE <= '0;
      VALUE_EN  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
`endif
    end else begin
      VALUE_EN <= 1'b0;
      case (state)
        SCAN: begin
          if (cnt == SCAN_LAST) begin
            cnt <= '0;
            if (!all_high) begin
              col_lat <= low_col;
              state   <= DEBOUNCE;
            end else begin
              row_idx <= row_next;
              KEY_ROW <= row_drive(row_next);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (col_p1[col_lat]) begin
            state <= SCAN;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            KEY_VALUE <= key_code;
            VALUE_EN  <= 1'b1;
            state     <= HOLD;
            cnt       <= '0;
`ifdef KEY_REPEAT_EN
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (all_high) begin
            state <= RELEASE;
            cnt   <= '0;
`ifdef KEY_REPEAT_EN
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
          end else if (!col_p1[col_lat]) begin
            // First repeat waits the long delay, later ones the shorter rate
            if (rpt_cnt == (rpt_first ? RPT_DLY_LAST : RPT_RATE_LAST)) begin
              VALUE_EN  <= 1'b1;
              rpt_cnt   <= '0;
              rpt_first <= 1'b0;
            end else begin
              rpt_cnt <= rpt_cnt + 1'b1;
            end
`endif
          end
        end
        RELEASE: begin
          if (!all_high) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            state   <= SCAN;
            cnt     <= '0;
            row_idx <= row_next;
            KEY_ROW <= row_drive(row_next);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  logic [3:0] digit_q [N_DIGIT];
  logic       is_digit;
  logic       is_bksp;
  logic       is_clear;

  always_comb begin
    is_digit = (MODE == 0) || (KEY_VALUE <= 4'd9);
    is_bksp  = (MODE != 0) && (KEY_VALUE == 4'd10);
    is_clear = (MODE != 0) && (KEY_VALUE == 4'd11);
  end

  // Entry buffer acts on the cycle after each accepted key; digit 0 is the newest
  always_ff @(posedge CLK) begin
    if (RST) begin
      ENTRY_CNT <= '0;
      for (int i = 0; i < N_DIGIT; i++) digit_q[i] <= '0;
    end else if (VALUE_EN) begin
      if (is_digit) begin
        if (ENTRY_CNT < DIGIT_MAX) begin
          for (int i = N_DIGIT - 1; i > 0; i--) digit_q[i] <= digit_q[i-1];
          digit_q[0] <= KEY_VALUE;
          ENTRY_CNT  <= ENTRY_CNT + 4'd1;
        end
      end else if (is_bksp) begin
        if (ENTRY_CNT != 4'd0) begin
          for (int i = 0; i < N_DIGIT - 1; i++) digit_q[i] <= digit_q[i+1];
          digit_q[N_DIGIT-1] <= '0;
          ENTRY_CNT <= ENTRY_CNT - 4'd1;
        end
      end else if (is_clear) begin
        for (int i = 0; i < N_DIGIT; i++) digit_q[i] <= '0;
        ENTRY_CNT <= '0;
      end
    end
  end

  logic [31:0]      ref_cnt;
  logic [DIG_W-1:0] dig_idx;
  logic [7:0]       disp_seg;

  always_comb begin
    if (4'(dig_idx) >= ENTRY_CNT)
      disp_seg = (dig_idx == '0) ? seg_decode(4'd0) : 8'hFF;
    else
      disp_seg = seg_decode(digit_q[dig_idx]);
  end

  // Stage p0 -> outputs: digit select and segments are registered together
  always_ff @(posedge CLK) begin
    if (RST) begin
      ref_cnt <= '0;
      dig_idx <= '0;
      SEL     <= ~N_DIGIT'(1);
      SEG     <= 8'hC0;
    end else begin
      if (ref_cnt == REF_LAST) begin
        ref_cnt <= '0;
        dig_idx <= (dig_idx == DIG_W'(N_DIGIT - 1)) ? '0 : dig_idx + 1'b1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
      SEL <= ~(N_DIGIT'(1) << dig_idx);
      SEG <= disp_seg;
    end
  end

endmodule

// File: tb/tb_keypad_entry_display.sv
// Bench for keypad_entry_display: a hex-mode and a decimal-mode instance share one keypad model;
// accepted-key events are checked against per-instance expectation queues.
`timescale 1ns/1ps
module tb_keypad_entry_display;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row_h, row_d, col_h, col_d, kv_h, kv_d, cnt_h, cnt_d, sel_h, sel_d;
  logic       vld_h, vld_d;
  logic [7:0] seg_h, seg_d;
  logic       press_on = 1'b0;
  logic [1:0] press_row = 2'd0;
  logic [1:0] press_col = 2'd0;
  logic [3:0] exp_h, exp_d, kr0;
  logic [3:0] q_h[$];
  logic [3:0] q_d[$];
  int         chk = 0;
  int         err = 0;

  always #5 clk = ~clk;

  assign col_h = (press_on && !row_h[press_row]) ? ~(4'b0001 << press_col) : 4'hF;
  assign col_d = (press_on && !row_d[press_row]) ? ~(4'b0001 << press_col) : 4'hF;

  keypad_entry_display #(
    .N_ROW(4), .N_COL(4), .N_DIGIT(4), .MODE(0), .SCAN_DIV(4), .DEB_CYCLES(8),
`ifdef KEY_REPEAT_EN
    .REPEAT_DLY(20), .REPEAT_RATE(10),
`endif
    .REFRESH_DIV(4)
  ) dut_h (
    .CLK(clk), .RST(rst), .KEY_ROW(row_h), .KEY_COL(col_h), .KEY_VALUE(kv_h),
    .VALUE_EN(vld_h), .ENTRY_CNT(cnt_h), .SEL(sel_h), .SEG(seg_h)
  );

  keypad_entry_display #(
    .N_ROW(4), .N_COL(4), .N_DIGIT(4), .MODE(1), .SCAN_DIV(4), .DEB_CYCLES(8),
`ifdef KEY_REPEAT_EN
    .REPEAT_DLY(20), .REPEAT_RATE(10),
`endif
    .REFRESH_DIV(4)
  ) dut_d (
    .CLK(clk), .RST(rst), .KEY_ROW(row_d), .KEY_COL(col_d), .KEY_VALUE(kv_d),
    .VALUE_EN(vld_d), .ENTRY_CNT(cnt_d), .SEL(sel_d), .SEG(seg_d)
  );

  always @(negedge clk) begin
    if (vld_h === 1'b1) begin
      chk++;
      if (q_h.size() == 0) begin
        err++;
        $display("FAIL ev_hex: unexpected event KEY_VALUE=%0d, none expected", kv_h);
      end else begin
        exp_h = q_h.pop_front();
        if (kv_h !== exp_h) begin
          err++;
          $display("FAIL ev_hex: KEY_VALUE=%0d, expected %0d", kv_h, exp_h);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (vld_d === 1'b1) begin
      chk++;
      if (q_d.size() == 0) begin
        err++;
        $display("FAIL ev_dec: unexpected event KEY_VALUE=%0d, none expected", kv_d);
      end else begin
        exp_d = q_d.pop_front();
        if (kv_d !== exp_d) begin
          err++;
          $display("FAIL ev_dec: KEY_VALUE=%0d, expected %0d", kv_d, exp_d);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    press_on = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_row_h", row_h, 4'b1110);
    check("rst_row_d", row_d, 4'b1110);
    check("rst_sel_h", sel_h, 4'b1110);
    check("rst_sel_d", sel_d, 4'b1110);
    check("rst_seg_h", seg_h, 8'hC0);
    check("rst_seg_d", seg_d, 8'hC0);
    check("rst_cnt_h", cnt_h, 0);
    check("rst_cnt_d", cnt_d, 0);
    check("rst_vld_h", vld_h, 0);
    check("rst_kv_h", kv_h, 0);
    rst = 1'b0;
  endtask

  task automatic press(input int code, input int hold, input bit keep);
    int n;
    press_row = 2'(code / 4);
    press_col = 2'(code % 4);
    press_on  = 1'b1;
    q_h.push_back(4'(code));
    q_d.push_back(4'(code));
    n = 0;
    while (vld_h !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("event_seen", n < 80, 1);
    repeat (hold) @(negedge clk);
    if (!keep) begin
      press_on = 1'b0;
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic check_digit(input bit dec, input int d, input logic [7:0] exp, input string name);
    int n;
    logic [3:0] want;
    want = ~(4'b0001 << d);
    n = 0;
    while (((dec ? sel_d : sel_h) !== want) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("digit_sel_seen", n < 40, 1);
    check(name, dec ? seg_d : seg_h, exp);
  endtask

  initial begin
    do_reset();

    press(9, 10, 0);
    check("k9_cnt_h", cnt_h, 1);
    check("k9_cnt_d", cnt_d, 1);
    check_digit(0, 0, 8'h90, "k9_d0");
    check_digit(0, 1, 8'hFF, "k9_d1");
    check_digit(0, 2, 8'hFF, "k9_d2");
    check_digit(0, 3, 8'hFF, "k9_d3");

    for (int i = 0; i < 3; i++) begin
      press_row = 2'd1;
      press_col = 2'd3;
      press_on  = 1'b1;
      repeat (5) @(negedge clk);
      press_on  = 1'b0;
      repeat (5) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    kr0 = row_h;
    repeat (5) @(negedge clk);
    check("bounce_scanning", row_h != kr0, 1);
    check("bounce_cnt_h", cnt_h, 1);

    press(6, 3, 1);
    check("hold_cnt_h", cnt_h, 2);
    do_reset();

    press(1, 3, 0);
    press(2, 3, 0);
    press(3, 3, 0);
    press(4, 3, 0);
    press(5, 3, 0);
    check("full_cnt_h", cnt_h, 4);
    check("full_cnt_d", cnt_d, 4);
    check_digit(0, 3, 8'hF9, "full_d3");
    check_digit(0, 2, 8'hA4, "full_d2");
    check_digit(0, 1, 8'hB0, "full_d1");
    check_digit(0, 0, 8'h99, "full_d0");
    check_digit(1, 0, 8'h99, "full_dec_d0");
    do_reset();

    press(7, 3, 0);
    press(8, 3, 0);
    check("d78_cnt_d", cnt_d, 2);
    check_digit(1, 1, 8'hF8, "d78_d1");
    check_digit(1, 0, 8'h80, "d78_d0");
    press(10, 3, 0);
    check("bksp_cnt_d", cnt_d, 1);
    check("hexA_cnt_h", cnt_h, 3);
    check_digit(1, 0, 8'hF8, "bksp_d0");
    check_digit(1, 1, 8'hFF, "bksp_d1");
    check_digit(0, 0, 8'h88, "hexA_d0");
    press(11, 3, 0);
    check("clr_cnt_d", cnt_d, 0);
    check("hexB_cnt_h", cnt_h, 4);
    check_digit(1, 0, 8'hC0, "clr_d0");
    check_digit(1, 1, 8'hFF, "clr_d1");
    check_digit(0, 0, 8'h83, "hexB_d0");
    check_digit(0, 3, 8'hF8, "hexB_d3");
    press(12, 3, 0);
    check("ign_cnt_d", cnt_d, 0);
    check("ign_cnt_h", cnt_h, 4);
    check_digit(1, 0, 8'hC0, "ign_d0");
    check_digit(0, 0, 8'h83, "ign_full_d0");

`ifdef KEY_REPEAT_EN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      q_h.push_back(4'd5);
      q_d.push_back(4'd5);
    end
    press(5, 65, 0);
    check("rpt_cnt_h", cnt_h, 4);
`endif

    repeat (5) @(negedge clk);
    check("queue_h_empty", q_h.size(), 0);
    check("queue_d_empty", q_d.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", chk, err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_entry_display.md
Name: keypad_entry_display

Overview:
Parametrised matrix-keypad scanner, numeric entry buffer and multiplexed 7-segment driver in one block. Generalises the fixed 4x4 keypad and single-value display to configurable rows, columns and digit count. Supports a hex or decimal entry mode, with backspace and clear in decimal mode. Sits at the board top level, between the keypad/tube pins and the user logic, which reads KEY_VALUE/VALUE_EN and ENTRY_CNT.

Parameters:
N_ROW, 4, keypad rows driven (2..4)
N_COL, 4, keypad columns sensed (2..4); N_ROW*N_COL <= 16
N_DIGIT, 8, number of 7-seg digits (1..8)
MODE, 0, 0 = hex entry (all codes are digits); 1 = decimal (codes 0-9 digits, 10 backspace, 11 clear, 12-15 ignored)
SCAN_DIV, 1000, cycles each row is driven before its columns are sampled
DEB_CYCLES, 200000, debounce interval, press and release
REFRESH_DIV, 50000, cycles each display digit is lit

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
KEY_ROW  out  N_ROW  row drive, active-low, one-cold
KEY_COL  in  N_COL  column sense, pulled up, low = pressed
KEY_VALUE  out  4  code of last accepted key = row*N_COL + col
VALUE_EN  out  1  one-cycle pulse per accepted key
ENTRY_CNT  out  4  digits currently entered (0..N_DIGIT)
SEL  out  N_DIGIT  digit enable, active-low, one-cold
SEG  out  8  segments {dp,g..a}, active-low; dp always off (bit7 = 1)

Behaviour:
- Reset: KEY_ROW = row 0 low, others high; KEY_VALUE = 0; VALUE_EN = 0; ENTRY_CNT = 0; buffer all 0; SEL = digit 0 low; SEG = 8'hC0 ('0'); FSM = SCAN; all counters 0.
- KEY_COL passes through a 2-FF synchroniser. All column references below use the synchronised value.
- Scan FSM states: SCAN, DEBOUNCE, HOLD, RELEASE.
- SCAN: drive the current row for SCAN_DIV cycles, then sample. Any column low: latch row and lowest-index low column, go DEBOUNCE. Otherwise advance to the next row, wrapping N_ROW-1 -> 0.
- DEBOUNCE: row stays driven and the counter runs.
  - Latched column goes high before DEB_CYCLES: return to SCAN on the same row, no event.
  - Counter reaches DEB_CYCLES: KEY_VALUE updates and VALUE_EN pulses for 1 cycle in the same cycle. Go HOLD.
- HOLD: wait for all columns high, then go RELEASE.
- RELEASE: requires all columns high for DEB_CYCLES consecutive cycles, then SCAN on the next row. Any low column restarts the count.
- Multiple keys pressed: only the first latched key is reported. No new event until full release.
- Entry buffer updates the cycle after VALUE_EN. Digit 0 is rightmost and newest.
  - Digit key, ENTRY_CNT < N_DIGIT: shift left by one, insert at digit 0, ENTRY_CNT++.
  - Digit key, buffer full: ignored, buffer unchanged.
  - Backspace: shift right, top digit <- 0, ENTRY_CNT-- (no-op when 0).
  - Clear: all digits 0, ENTRY_CNT = 0.
  - Ignored codes: VALUE_EN still pulses, buffer unchanged.
- Display:
  - Refresh counter advances the digit index every REFRESH_DIV cycles, wrapping N_DIGIT-1 -> 0.
  - SEL/SEG are registered, so 1 cycle latency from an index or buffer change.
  - Digit index >= ENTRY_CNT is blanked (SEG = 8'hFF), except digit 0 shows '0' when ENTRY_CNT = 0.
  - Hex decode: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- RST asserted mid-operation restores all reset values on the next edge. No partial event is emitted.

Optional Feature:
KEY_REPEAT_EN.
- Defined: adds parameters REPEAT_DLY (default 25000000) and REPEAT_RATE (default 5000000).
  - In HOLD with the latched column still low, a repeat VALUE_EN with the same KEY_VALUE fires REPEAT_DLY cycles after the first event.
  - Further repeats fire every REPEAT_RATE cycles.
  - The repeat counter clears on release or RST.
- Undefined: exactly one event per press; the repeat counters do not exist.

Test Plan:
- Sim params N_ROW=4, N_COL=4, N_DIGIT=4, SCAN_DIV=4, DEB_CYCLES=8, REFRESH_DIV=4.
- Reset: RST high 3 cycles -> KEY_ROW=4'b1110, SEL=4'b1110, SEG=8'hC0, ENTRY_CNT=0, VALUE_EN=0.
- MODE=0, hold row 2/col 1 (code 9) for 40 cycles, then release -> exactly one VALUE_EN with KEY_VALUE=9; ENTRY_CNT=1; digit 0 shows SEG=8'h90; digits 1-3 show 8'hFF.
- Bounce: press row 1/col 3 for 5 cycles, release, repeat 3 times -> no VALUE_EN; FSM back in SCAN.
- MODE=0, enter codes 1,2,3,4,5 -> ENTRY_CNT=4; digits 3..0 = 1,2,3,4; the fifth key pulses VALUE_EN but the buffer is unchanged.
- MODE=1, enter 7,8 then code 10, then code 11 -> after backspace ENTRY_CNT=1 and digit0=7; after clear ENTRY_CNT=0 and digit 0 shows C0.
- KEY_REPEAT_EN with REPEAT_DLY=20, REPEAT_RATE=10: hold code 5 for 60 cycles past the first event -> 1 + 1 + 4 VALUE_EN pulses, all KEY_VALUE=5.
